avalon_bus_arbiter: RTL
=======================

AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width BE_W = DATA_W/8.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_address  in  ADDR_W  master 0 (instruction fetch) address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_byteenable  in  BE_W  master 0 byte lanes.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdata  out  DATA_W  master 0 read data.
- m1_*  (same set as m0_*)  master 1 (load/store).
- s_address  out  ADDR_W  shared memory address.
- s_read  out  1  shared memory read.
- s_write  out  1  shared memory write.
- s_byteenable  out  BE_W  shared memory byte lanes.
- s_writedata  out  DATA_W  shared memory write data.
- s_waitrequest  in  1  memory stall.
- s_readdata  in  DATA_W  memory read data, valid in the completing cycle.
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1.

Function
REQ-003 A master requests when its read or write is high.
REQ-004 A requesting master SHALL hold address, byteenable, writedata and command stable until it sees its waitrequest low.
REQ-005 The FSM SHALL have three states:
- IDLE: grant = 00.
- OWN0: grant = 01.
- OWN1: grant = 10.
REQ-006 A round-robin pointer last (1 bit) SHALL record the master most recently granted.
REQ-007 In IDLE:
- Exactly one request: the next edge SHALL enter that master's OWN state.
- Both requests: the next edge SHALL enter the OWN state of the master not equal to last.
- No request: remain in IDLE.
REQ-008 Command timing: a request first seen in IDLE in cycle N SHALL appear on the s_ port in cycle N+1. Grant latency is one cycle.
REQ-009 In OWNx, the s_ outputs SHALL combinationally equal master x's inputs.
REQ-010 In OWNx, mx_waitrequest SHALL equal s_waitrequest.
REQ-011 In OWNx, mx_readdata SHALL equal s_readdata.
REQ-012 The non-owning master SHALL see waitrequest = 1 and readdata = 0 at all times.
REQ-013 In IDLE, both waitrequests SHALL be 1.
REQ-014 In IDLE, s_read and s_write SHALL be 0, and s_address, s_byteenable and s_writedata SHALL be 0.
REQ-015 Completion occurs in a cycle where the state is OWNx, mx_read or mx_write is high, and s_waitrequest = 0.
REQ-016 On completion, last SHALL become x.
REQ-017 On completion, the next state SHALL be chosen from the requests sampled in the same cycle, using the rule in REQ-007 with the updated last value. Back-to-back transfers occur with no IDLE bubble.
REQ-018 If only master x requests at completion, the arbiter SHALL re-grant x. A single master can issue one transfer per cycle when memory has zero wait states.
REQ-019 If the owner drops both read and write before completion (a protocol violation), the arbiter SHALL return to IDLE on the next edge and issue no transfer.
REQ-020 If a master asserts read and write together, write SHALL take precedence: s_write follows the master and s_read is forced to 0.
REQ-021 Multi-cycle s_waitrequest SHALL hold the state in OWNx indefinitely, with no timeout.

Reset
REQ-022 While reset = 0, outputs SHALL be forced asynchronously:
- state IDLE, last = 1, grant = 00.
- s_read = 0, s_write = 0, all s_ data/address/byteenable outputs 0.
- m0_waitrequest = m1_waitrequest = 1, readdata outputs 0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no further memory command. After reset release, m0 wins the first simultaneous request.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Single read: m0_read with address 0xBFC00000 at cycle 2, s_waitrequest 0 -> s_read at cycle 3; m0_readdata = s_readdata, m0_waitrequest 0 at cycle 3; back to IDLE at cycle 4.
- Simultaneous requests after reset: m0 LW fetch and m1 SW to address 200 with data 404 -> m0 served first, then m1 the next cycle with s_writedata 404 and byteenable 1111; grant sequence 01, 10.
- Wait states: s_waitrequest high for 3 cycles during an m1 read -> m1_waitrequest high for 3 cycles; m0 stays stalled; s_address stable throughout.
- Round-robin fairness: both masters continuously requesting for 10 transfers -> grant alternates 01/10, with exactly 5 transfers each.
- Read+write collision: m1_read = m1_write = 1 -> s_write = 1, s_read = 0.
- Reset pulse during OWN1 with s_waitrequest high -> s_write drops immediately, grant = 00; after release, a request is serviced normally.

Source files
------------

// File: rtl/avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter in front of one shared memory port.
// Round-robin grant, no IDLE bubble between back-to-back transfers.
module avalon_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q,  last_d;

  logic req0;
  logic req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Round-robin choice: a lone requester wins,
  // a tie goes to the master that was not served last.
  function automatic state_e pick(
    input logic r0,
    input logic r1,
    input logic lst
  );
    state_e s;
    s = IDLE;
    if (r0 && r1)
      s = lst ? OWN0 : OWN1;
    else if (r0)
      s = OWN0;
    else if (r1)
      s = OWN1;
    return s;
  endfunction

  // State and round-robin pointer registers.
  // last resets to 1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: hold through wait states, re-arbitrate
  // on completion, drop to IDLE if the owner abandons.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        state_d = pick(req0, req1, last_q);
      end
      OWN0: begin
        if (!req0) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_d  = 1'b0;
          state_d = pick(req0, req1, 1'b0);
        end
      end
      OWN1: begin
        if (!req1) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_d  = 1'b1;
          state_d = pick(req0, req1, 1'b1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  logic own0;
  logic own1;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  // Output mux: owner is wired straight through to memory,
  // everyone else is stalled and sees zero read data.
  // Write beats read when a master raises both.
  always_comb begin
    grant          = 2'b00;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_byteenable   = '0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    unique case (1'b1)
      own0: begin
        grant          = 2'b01;
        s_address      = m0_address;
        s_write        = m0_write;
        s_read         = m0_read & ~m0_write;
        s_byteenable   = m0_byteenable;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
      end
      own1: begin
        grant          = 2'b10;
        s_address      = m1_address;
        s_write        = m1_write;
        s_read         = m1_read & ~m1_write;
        s_byteenable   = m1_byteenable;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  logic [BE_W-1:0] be_unused;
  assign be_unused = '0;

endmodule
